// File: rtl/config_pkg.sv
// Shared types and constants for the configuration-chain loader.
// The state enum includes CHECK, which is only reachable when CONFIG_LOADER_CRC_EN is defined.
package config_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/config_crc16.sv
// Serial CRC-16-CCITT (MSB-first, no reflection). Each bit is folded in on a cycle with bit_en high.
// clear has priority over bit_en and restores the init value.
module config_crc16
    import config_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[15] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (bit_en) begin
            crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/config_loader.sv
// Serial bitstream driver for the fabric configuration chain: accepts words over valid/ready
// and shifts them out LSB first. Optional trailing CRC check word under CONFIG_LOADER_CRC_EN.
//
// Handshake: word_in is taken on a cycle where word_valid && word_ready are both high at the
// clock edge; word_valid may stall freely, and word_ready is only offered in LOAD/CHECK.
module config_loader
    import config_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic              config_clk,
    input  logic              config_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              config_in,
    output logic              config_en,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        dbg_state
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   shreg;
    logic [BIT_W-1:0]    bit_idx;
    logic [CNT_W-1:0]    bit_cnt;
    logic                handshake;
    logic                start_ok;
    logic                abort_ok;
    logic                last_bit;
    logic                word_end;

    assign handshake = word_valid & word_ready;
    assign start_ok  = (state == IDLE) & start;
    assign abort_ok  = (state != IDLE) & abort;
    assign last_bit  = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign word_end  = (bit_idx == BIT_W'(WORD_W - 1));

    // The chain count ends the load even mid-word, so unused upper bits of the last word never shift out.
    always_comb begin
        next_state = state;
        word_ready = 1'b0;
        config_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid) next_state = SHIFT;
            end
            SHIFT: begin
                config_en = 1'b1;
                if (last_bit) begin
`ifdef CONFIG_LOADER_CRC_EN
                    next_state = CHECK;
`else
                    next_state = DONE;
`endif
                end else if (word_end) begin
                    next_state = LOAD;
                end
            end
`ifdef CONFIG_LOADER_CRC_EN
            CHECK: begin
                word_ready = 1'b1;
                if (word_valid) next_state = DONE;
            end
`endif
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // abort overrides the handshake and the final bit in the same cycle
        if (abort_ok) begin
            next_state = DONE;
            word_ready = 1'b0;
            config_en  = 1'b0;
        end
    end

    assign config_in = config_en & shreg[0];
    assign busy      = (state == LOAD) | (state == SHIFT) | (state == CHECK);
    assign done      = (state == DONE);
    assign dbg_state = state;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc;

    config_crc16 u_crc (
        .clk    (config_clk),
        .rst_n  (config_rst_n),
        .clear  (start_ok),
        .bit_en (config_en),
        .bit_in (config_in),
        .crc    (crc)
    );
`endif

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state <= next_state;
            if (start_ok) begin
                bit_cnt <= '0;
                err     <= 1'b0;
            end
            if (handshake && state == LOAD) begin
                shreg   <= word_in;
                bit_idx <= '0;
            end
            if (config_en) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + BIT_W'(1);
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
`ifdef CONFIG_LOADER_CRC_EN
            if (handshake && state == CHECK) begin
                err <= (word_in[15:0] != crc);
            end
`endif
            if (abort_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a bit-queue model of the expected serial stream plus
// per-load totals. Define CONFIG_LOADER_CRC_EN to run the CRC scenario instead.
module tb_config_loader;

`ifdef CONFIG_LOADER_CRC_EN
    localparam int WORD_W    = 16;
    localparam int CHAIN_LEN = 16;
`else
    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;
`endif

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              config_in;
    logic              config_en;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        dbg_state;

    config_loader #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN),
        .CNT_W     (16)
    ) dut (
        .config_clk   (clk),
        .config_rst_n (rst_n),
        .start        (start),
        .abort        (abort),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .config_in    (config_in),
        .config_en    (config_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // model and bookkeeping
    typedef struct {
        logic [WORD_W-1:0] word;
        int                gap;
    } feed_t;

    feed_t      feed_q[$];
    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];
    int         model_bits;
    int         n_checks;
    int         n_errors;
    int         en_count;
    int         done_count;
    int         busy_count;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // compare process: every enabled cycle must carry the next expected chain bit
    always @(negedge clk) begin
        if (rst_n) begin
            if (config_en) begin
                en_count++;
                obs_q.push_back(config_in);
                if (exp_q.size() == 0) begin
                    check("extra_enable", 1, 0);
                end else begin
                    check("config_in", int'(config_in), int'(exp_q.pop_front()));
                end
            end
            if (busy) busy_count++;
            if (done) begin
                done_count++;
                check("busy_during_done", int'(busy), 0);
            end
        end
    end

    // word driver: honours per-word gaps counted only on cycles the loader is ready
    initial begin
        logic hs_seen;
        logic ready_seen;
        feed_t f;
        word_valid = 1'b0;
        word_in    = '0;
        forever begin
            @(negedge clk);
            hs_seen    = word_valid & word_ready;
            ready_seen = word_ready;
            @(posedge clk);
            #1;
            if (hs_seen && feed_q.size() > 0) begin
                void'(feed_q.pop_front());
            end else if (feed_q.size() > 0 && ready_seen && feed_q[0].gap > 0) begin
                f = feed_q[0];
                f.gap--;
                feed_q[0] = f;
            end
            if (feed_q.size() > 0 && feed_q[0].gap == 0) begin
                word_valid = 1'b1;
                word_in    = feed_q[0].word;
            end else begin
                word_valid = 1'b0;
                word_in    = '0;
            end
        end
    end

    // driver tasks
    task automatic clear_model();
        feed_q.delete();
        exp_q.delete();
        obs_q.delete();
        model_bits = 0;
        en_count   = 0;
        done_count = 0;
        busy_count = 0;
    endtask

    task automatic add_word(input logic [WORD_W-1:0] w, input int gap, input bit to_chain);
        feed_t f;
        f.word = w;
        f.gap  = gap;
        feed_q.push_back(f);
        if (to_chain) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (model_bits < CHAIN_LEN) begin
                    exp_q.push_back(w[b]);
                    model_bits++;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_enables(input int n, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(posedge clk);
            hit = (en_count >= n);
        end
        if (!hit) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic finish_load(input string name, input int exp_en, input int exp_err,
                               input int exp_busy, input int exp_left);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({name, "_done_timeout"}, 0, 1);
        @(negedge clk);
        @(negedge clk);
        check({name, "_enables"}, en_count, exp_en);
        check({name, "_done_pulses"}, done_count, 1);
        check({name, "_err"}, int'(err), exp_err);
        check({name, "_busy_cycles"}, busy_count, exp_busy);
        check({name, "_bits_left"}, exp_q.size(), exp_left);
        check({name, "_idle_busy"}, int'(busy), 0);
    endtask

    function automatic logic [31:0] obs_vector();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < obs_q.size() && i < 32; i++) v[i] = obs_q[i];
        return v;
    endfunction

`ifdef CONFIG_LOADER_CRC_EN
    function automatic logic [15:0] crc_of(input logic [0:0] bits[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (bits[i]) begin
            if (c[15] ^ bits[i][0]) c = (c << 1) ^ 16'h1021;
            else                    c = c << 1;
        end
        return c;
    endfunction
`endif

    // stimulus
    initial begin
        logic [15:0] crc_word;
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        abort    = 1'b0;
        rst_n    = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", int'(word_ready), 0);
        check("reset_en", int'(config_en), 0);
        check("reset_outs", int'({config_in, busy, done, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

`ifdef CONFIG_LOADER_CRC_EN
        // correct CRC word: chain sees 16 bits, err stays clear
        clear_model();
        add_word(16'h0000, 0, 1'b1);
        crc_word = crc_of(exp_q);
        add_word(crc_word, 0, 1'b0);
        pulse_start();
        finish_load("crc_ok", 16, 0, 18, 0);

        // corrupted CRC word flags err, chain still sees 16 bits
        clear_model();
        add_word(16'h0000, 0, 1'b1);
        crc_word = crc_of(exp_q) ^ 16'h0001;
        add_word(crc_word, 0, 1'b0);
        pulse_start();
        finish_load("crc_bad", 16, 1, 18, 0);
        check("crc_bad_no_extra_words", feed_q.size(), 0);
`else
        // basic three-word load; also pin the stream to a hand-computed literal
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        finish_load("basic", 20, 0, 23, 0);
        check("basic_stream", int'(obs_vector()), 32'h000F3CA5);

        // valid withheld five cycles before word 2
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 5, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        finish_load("stall", 20, 0, 28, 0);
        check("stall_stream", int'(obs_vector()), 32'h000F3CA5);

        // abort after 10 bits
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        wait_enables(10, "abort_wait");
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_en_low", int'(config_en), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        finish_load("abort", 10, 1, 13, 10);

        // a fresh start clears the sticky err
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        @(negedge clk);
        check("restart_err_clear", int'(err), 0);
        finish_load("restart", 20, 0, 23, 0);

        // start pulsed mid-shift is ignored
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        wait_enables(3, "restart_wait");
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        finish_load("ignored_start", 20, 0, 23, 0);
        check("ignored_start_stream", int'(obs_vector()), 32'h000F3CA5);

        // asynchronous reset after 6 bits
        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        wait_enables(6, "reset_wait");
        #3 rst_n = 1'b0;
        #1;
        check("midreset_en", int'(config_en), 0);
        check("midreset_outs", int'({word_ready, config_in, busy, done, err}), 0);
        feed_q.delete();
        repeat (3) @(posedge clk);
        check("midreset_no_done", done_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        clear_model();
        add_word(8'hA5, 0, 1'b1);
        add_word(8'h3C, 0, 1'b1);
        add_word(8'h0F, 0, 1'b1);
        pulse_start();
        finish_load("after_reset", 20, 0, 23, 0);
        check("after_reset_stream", int'(obs_vector()), 32'h000F3CA5);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
